// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - PS/2 line, clear and key-report bundle for ps2_keyboard_rx
interface ps2_keyboard_rx_if;
  logic       iPS2Clk;
  logic       iPS2Data;
  logic       iClear;
  logic [7:0] oData;
  logic       oKeyboardFlag;
  logic       oExtended;
  logic       oParityError;
  logic       oFrameError;

  modport master (
    output iPS2Clk, iPS2Data, iClear,
    input  oData, oKeyboardFlag, oExtended, oParityError, oFrameError
  );

  modport slave (
    input  iPS2Clk, iPS2Data, iClear,
    output oData, oKeyboardFlag, oExtended, oParityError, oFrameError
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver reporting key releases (F0 / E0 F0 sequences)
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FLAG_CYCLES    = 16
) (
  input logic              Clock,
  input logic              Reset,
  ps2_keyboard_rx_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int GW = $clog2(FLAG_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [16:0]   TO_LAST   = 17'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] FLAG_LAST = GW'(FLAG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_f_q, clk_f_d, dat_f_q, dat_f_d, clk_prev_q;
  logic [FW-1:0] clk_fcnt_q, clk_fcnt_d, dat_fcnt_q, dat_fcnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [16:0]   to_cnt_q, to_cnt_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]    data_q, data_d, pend_data_q, pend_data_d;
  logic          ext_q, ext_d, pend_ext_q, pend_ext_d;
  logic          flag_q, flag_d, restart_q, restart_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          perr_q, perr_d, ferr_q, ferr_d;

  logic fall, timeout, start_bit, shift_en, par_en, stop_en, count_en;
  logic frame_ok, report;

  // A filtered level only moves after FILTER_LEN straight samples of the opposite level
  always_comb begin
    clk_f_d    = clk_f_q;
    clk_fcnt_d = '0;
    if (clk_s2_q != clk_f_q) begin
      if (clk_fcnt_q == FILT_LAST) clk_f_d = clk_s2_q;
      else                         clk_fcnt_d = clk_fcnt_q + 1'b1;
    end
    dat_f_d    = dat_f_q;
    dat_fcnt_d = '0;
    if (dat_s2_q != dat_f_q) begin
      if (dat_fcnt_q == FILT_LAST) dat_f_d = dat_s2_q;
      else                         dat_fcnt_d = dat_fcnt_q + 1'b1;
    end
  end

  assign fall    = clk_prev_q & ~clk_f_q;
  assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_f_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start_bit = fall && (state_q == IDLE) && !dat_f_q;
    shift_en  = fall && (state_q == DATA);
    par_en    = fall && (state_q == PARITY);
    stop_en   = fall && (state_q == STOP);
    count_en  = (state_q != IDLE);
  end

  assign frame_ok = stop_en && dat_f_q && (^{shift_q, par_q});
  assign report   = frame_ok && brk_pend_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if (start_bit) bit_cnt_d = '0;
    if (shift_en) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      shift_d   = {dat_f_q, shift_q[7:1]};
    end
    if (par_en) par_d = dat_f_q;
    to_cnt_d = (fall || !count_en || timeout) ? '0 : to_cnt_q + 1'b1;
    perr_d   = stop_en && dat_f_q && !(^{shift_q, par_q});
    ferr_d   = (stop_en && !dat_f_q) || timeout;

    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    if (frame_ok) begin
      if (shift_q == 8'hE0)      ext_pend_d = 1'b1;
      else if (shift_q == 8'hF0) brk_pend_d = 1'b1;
      else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // oData only changes when the flag rises, so each falling edge sees its own report
  always_comb begin
    data_d      = data_q;
    ext_d       = ext_q;
    pend_data_d = pend_data_q;
    pend_ext_d  = pend_ext_q;
    flag_d      = flag_q;
    gcnt_d      = gcnt_q;
    restart_d   = 1'b0;
    if (report) begin
      if (flag_q || restart_q) begin
        flag_d      = 1'b0;
        pend_data_d = shift_q;
        pend_ext_d  = ext_pend_q;
        restart_d   = 1'b1;
      end else begin
        data_d = shift_q;
        ext_d  = ext_pend_q;
        flag_d = 1'b1;
        gcnt_d = FLAG_LAST;
      end
    end else if (restart_q) begin
      data_d = pend_data_q;
      ext_d  = pend_ext_q;
      flag_d = 1'b1;
      gcnt_d = FLAG_LAST;
    end else if (flag_q) begin
      if (bus.iClear || gcnt_q == '0) flag_d = 1'b0;
      else                            gcnt_d = gcnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      clk_f_q     <= 1'b1;
      dat_f_q     <= 1'b1;
      clk_prev_q  <= 1'b1;
      clk_fcnt_q  <= '0;
      dat_fcnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      data_q      <= '0;
      ext_q       <= 1'b0;
      pend_data_q <= '0;
      pend_ext_q  <= 1'b0;
      flag_q      <= 1'b0;
      restart_q   <= 1'b0;
      gcnt_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      clk_s1_q    <= bus.iPS2Clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= bus.iPS2Data;
      dat_s2_q    <= dat_s1_q;
      clk_f_q     <= clk_f_d;
      dat_f_q     <= dat_f_d;
      clk_prev_q  <= clk_f_q;
      clk_fcnt_q  <= clk_fcnt_d;
      dat_fcnt_q  <= dat_fcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      data_q      <= data_d;
      ext_q       <= ext_d;
      pend_data_q <= pend_data_d;
      pend_ext_q  <= pend_ext_d;
      flag_q      <= flag_d;
      restart_q   <= restart_d;
      gcnt_q      <= gcnt_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign bus.oData         = data_q;
  assign bus.oExtended     = ext_q;
  assign bus.oKeyboardFlag = flag_q;
  assign bus.oParityError  = perr_q;
  assign bus.oFrameError   = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
  localparam int FILT = 8;
  localparam int TOUT = 1000;
  localparam int FLAGC = 16;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(
    .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TOUT), .FLAG_CYCLES(FLAGC)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_low = 0;

  int falls = 0, flag_len = 0, last_len = 0, flag_rise = 0;
  logic [7:0] fall_hist[$];
  logic [7:0] fall_data = 8'h00;
  logic fall_ext = 1'b0, flag_prev = 1'b0;
  int perr_cnt = 0, ferr_cnt = 0, perr_wide = 0, ferr_wide = 0, ferr_rise = 0;
  logic perr_prev = 1'b0, ferr_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.oKeyboardFlag) begin
      if (!flag_prev) begin
        flag_rise = cyc;
        flag_len  = 0;
      end
      flag_len++;
    end else if (flag_prev) begin
      last_len  = flag_len;
      falls++;
      fall_data = bus.oData;
      fall_ext  = bus.oExtended;
      fall_hist.push_back(bus.oData);
    end
    flag_prev = bus.oKeyboardFlag;
    if (bus.oParityError) begin
      if (perr_prev) perr_wide++;
      else           perr_cnt++;
    end
    perr_prev = bus.oParityError;
    if (bus.oFrameError) begin
      if (ferr_prev) ferr_wide++;
      else begin
        ferr_cnt++;
        ferr_rise = cyc;
      end
    end
    ferr_prev = bus.oFrameError;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.iPS2Data = b;
    wait_cycles(HALF);
    bus.iPS2Clk = 1'b0;
    last_low = cyc;
    wait_cycles(HALF);
    bus.iPS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    bus.iPS2Data = 1'b1;
    wait_cycles(2 * HALF);
  endtask

  initial begin
    int base;
    int low;
    logic [7:0] f0;
    bus.iPS2Clk  = 1'b1;
    bus.iPS2Data = 1'b1;
    bus.iClear   = 1'b0;
    wait_cycles(5);
    check("rst_data", 32'(bus.oData), 32'h00);
    check("rst_flag", 32'(bus.oKeyboardFlag), 0);
    check("rst_ext", 32'(bus.oExtended), 0);
    check("rst_perr", 32'(bus.oParityError), 0);
    check("rst_ferr", 32'(bus.oFrameError), 0);
    rst = 1'b0;
    wait_cycles(50);
    check("no_spurious_edge", 32'(dut.state_q), 0);

    // make code alone, then break sequence
    send_frame(8'h1D, 1'b0);
    check("make_no_flag", 32'(falls), 0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("brk1_falls", 32'(falls), 1);
    check("brk1_data", 32'(fall_data), 32'h1D);
    check("brk1_ext", 32'(fall_ext), 0);
    check("brk1_len", 32'(last_len), FLAGC);
    check("brk1_rise", 32'(flag_rise - last_low), FILT + 3);

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    check("ext_falls", 32'(falls), 2);
    check("ext_data", 32'(fall_data), 32'h5A);
    check("ext_ext", 32'(fall_ext), 1);

    send_frame(8'h23, 1'b1);
    check("par_pulse", 32'(perr_cnt), 1);
    check("par_width", 32'(perr_wide), 0);
    check("par_no_flag", 32'(falls), 2);
    check("par_data_hold", 32'(bus.oData), 32'h5A);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    check("par_next_data", 32'(fall_data), 32'h23);
    check("par_next_ext", 32'(fall_ext), 0);
    check("no_ferr_yet", 32'(ferr_cnt), 0);

    // partial frame: start + 5 data bits, then the clock stops
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.iPS2Data = 1'b0;
    wait_cycles(HALF);
    bus.iPS2Clk = 1'b0;
    low = cyc;
    base = ferr_cnt;
    for (int n = 0; n < TOUT + 400 && ferr_cnt == base; n++) begin
      @(negedge clk);
      if (n == HALF) bus.iPS2Clk = 1'b1;
    end
    bus.iPS2Clk = 1'b1;
    bus.iPS2Data = 1'b1;
    wait_cycles(4);
    check("to_pulse", 32'(ferr_cnt), 1);
    check("to_delay", 32'(ferr_rise - low), FILT + 3 + TOUT);
    check("to_width", 32'(ferr_wide), 0);
    check("to_idle", 32'(dut.state_q), 0);
    check("to_data_hold", 32'(bus.oData), 32'h23);
    wait_cycles(2 * HALF);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h4B, 1'b0);
    check("to_next_falls", 32'(falls), 4);
    check("to_next_data", 32'(fall_data), 32'h4B);

    // early clear three cycles after the flag rises
    send_frame(8'hF0, 1'b0);
    fork
      send_frame(8'h1C, 1'b0);
      begin
        int k;
        k = 0;
        while (!bus.oKeyboardFlag && k < 3000) begin
          @(negedge clk);
          k++;
        end
        wait_cycles(3);
        bus.iClear = 1'b1;
        wait_cycles(1);
        bus.iClear = 1'b0;
      end
    join
    check("clr_len", 32'(last_len), 4);
    check("clr_data", 32'(fall_data), 32'h1C);

    base = falls;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h32, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h33, 1'b0);
    check("b2b_falls", 32'(falls - base), 2);
    check("b2b_first", 32'(fall_hist[base]), 32'h32);
    check("b2b_second", 32'(fall_hist[base + 1]), 32'h33);

    // reset during data bit 4 of an F0 frame
    f0 = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(f0[i]);
    bus.iPS2Data = f0[3];
    wait_cycles(20);
    rst = 1'b1;
    #1;
    check("mid_rst_data", 32'(bus.oData), 32'h00);
    check("mid_rst_flag", 32'(bus.oKeyboardFlag), 0);
    check("mid_rst_ext", 32'(bus.oExtended), 0);
    wait_cycles(10);
    bus.iPS2Clk = 1'b1;
    bus.iPS2Data = 1'b1;
    rst = 1'b0;
    wait_cycles(2 * HALF);
    base = falls;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("post_rst_falls", 32'(falls - base), 1);
    check("post_rst_data", 32'(bus.oData), 32'h1C);
    check("post_rst_ext", 32'(bus.oExtended), 0);
    check("post_rst_ferr", 32'(ferr_cnt), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical Clock samples needed before a filtered PS/2 line level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: maximum Clock cycles allowed between PS/2 falling edges inside one frame.
REQ-003 Parameter FLAG_CYCLES, default 16: number of Clock cycles oKeyboardFlag stays high per reported key.
REQ-004 Clock  input  1  system clock; the single clock of the block.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 iPS2Clk  input  1  raw PS/2 clock line, asynchronous to Clock.
REQ-007 iPS2Data  input  1  raw PS/2 data line, asynchronous to Clock.
REQ-008 iClear  input  1  consumer request to drop oKeyboardFlag early.
REQ-009 oData  output  8  scancode of the last released key.
REQ-010 oKeyboardFlag  output  1  high for FLAG_CYCLES when a new key release is reported; consumers act on its falling edge.
REQ-011 oExtended  output  1  1 when the reported code was E0-prefixed.
REQ-012 oParityError  output  1  one-cycle pulse when a frame fails the parity check.
REQ-013 oFrameError  output  1  one-cycle pulse on a bad stop bit or an intra-frame timeout.

Function
REQ-014 Synchronizers: iPS2Clk and iPS2Data SHALL each pass through a 2-flop synchronizer.
REQ-015 Filtering: each synchronized line SHALL then pass a FILTER_LEN glitch filter.
REQ-016 Edge detect: a PS/2 falling edge is a 1->0 transition of the filtered clock; data SHALL be sampled from the filtered data line in that same cycle.
REQ-017 FSM states: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: a falling edge with data=0 SHALL go to DATA and clear the bit counter; a falling edge with data=1 SHALL be ignored and stay in IDLE.
REQ-019 DATA: the block SHALL shift 8 bits, LSB first, one per falling edge, then go to PARITY.
REQ-020 PARITY: the block SHALL capture the parity bit and go to STOP.
REQ-021 STOP: the next falling edge SHALL return the FSM to IDLE; the frame is valid only if the stop bit is 1 and data plus parity hold an odd number of ones.
REQ-022 Parity fail: oParityError SHALL pulse and the byte SHALL be discarded.
REQ-023 Stop-bit fail: oFrameError SHALL pulse and the byte SHALL be discarded.
REQ-024 Timeout: an 17-bit counter SHALL clear on each falling edge and count in DATA, PARITY and STOP; at TIMEOUT_CYCLES it SHALL force IDLE, pulse oFrameError and discard the partial byte.
REQ-025 Decode, 0xE0: SHALL set the ext_pending bit.
REQ-026 Decode, 0xF0: SHALL set the brk_pending bit.
REQ-027 Decode, other byte with brk_pending=1: SHALL load oData=byte and oExtended=ext_pending, start the flag, and clear both pending bits.
REQ-028 Decode, other byte with brk_pending=0 (make code or typematic repeat): SHALL report nothing and clear ext_pending.
REQ-029 Flag timing: oKeyboardFlag SHALL rise in the cycle after the stop edge of the reporting frame and fall after exactly FLAG_CYCLES cycles.
REQ-030 iClear: if high while the flag is high, the flag SHALL fall on the next cycle.
REQ-031 Flag restart: a new report while the flag is high SHALL force the flag low for 1 cycle, then restart it with the new oData, so a falling edge always separates reports.
REQ-032 oData stability: oData and oExtended SHALL hold their value until the next report.
REQ-033 Error pulses: error pulses SHALL not change oData, oKeyboardFlag or the pending bits.

Reset
REQ-034 Reset SHALL asynchronously force the FSM to IDLE.
REQ-035 Reset SHALL clear every counter, the shift register and both pending bits.
REQ-036 Reset SHALL drive oData=8'h00 and every other output to 0.
REQ-037 Reset mid-frame SHALL drop the partial frame; the first frame with a start bit after release SHALL be decoded normally.
REQ-038 Filter state SHALL reset to 1 (idle line level), so release with idle lines produces no spurious edge.

Verification
REQ-039 Frames 0x1D, 0xF0, 0x1D (10 kHz PS/2 clock) -> one report, oData=0x1D, oExtended=0, flag high exactly 16 cycles; the 0x1D make code alone produces no flag.
REQ-040 Frames 0xE0, 0xF0, 0x5A -> oData=0x5A, oExtended=1, flag pulse.
REQ-041 Frame 0x23 with even parity -> oParityError 1-cycle pulse, no flag, oData unchanged; a following F0 23 reports 0x23.
REQ-042 Send 5 bits then stop clocking -> oFrameError pulse exactly TIMEOUT_CYCLES after the last edge, FSM in IDLE; the next full frame decodes correctly.
REQ-043 Assert iClear 3 cycles after the flag rises -> flag low on the next cycle; two back-to-back releases -> two distinct falling edges with the correct oData at each.
REQ-044 Assert Reset during bit 4 of F0 -> all outputs 0 immediately; after release, F0 1C -> oData=0x1C.
